counter: RTL and testbench

- Free-running modulo-N up-counter: one increment per rising clock edge, wrapping from N-1 back to 0.
- Counter width equals N bits; only the low range 0..N-1 is ever used.
- Used as a general timebase/sequencer in the design: the q output feeds downstream decode logic, and tc marks the last count of each period.

---
 rtl/counter.sv | 36 +++
 tb/tb_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running modulo-N up-counter used as a timebase; tc flags the last count of each period.
// q uses N bits but only ever holds 0..N-1.
module counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] q,
    output logic         tc
);

    if (N < 2) begin : g_bad_n
        $error("counter: N must be >= 2, got %0d", N);
    end

    localparam logic [N-1:0] LAST = N'(N - 1);

    // Wrap on an explicit compare with N-1 so the upper codes of the register are never reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (q == LAST)
            q <= '0;
        else
            q <= q + N'(1);
    end

    assign tc = (q == LAST);

    a_q_in_range : assert property (@(posedge clk) disable iff (reset) q <= LAST);

    always_comb begin
        a_tc_decode : assert (tc == (q == LAST));
    end

endmodule

// File: tb/tb_counter.sv
// Randomized self-checking bench for counter at N = 8, 5 and 2 sharing one clock and reset.
// Reference: expected count is simply (edges since reset release) mod N.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] q8;
    logic       tc8;
    logic [4:0] q5;
    logic       tc5;
    logic [1:0] q2;
    logic       tc2;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    counter #(.N(8)) dut8 (.clk(clk), .reset(reset), .q(q8), .tc(tc8));
    counter #(.N(5)) dut5 (.clk(clk), .reset(reset), .q(q5), .tc(tc5));
    counter #(.N(2)) dut2 (.clk(clk), .reset(reset), .q(q2), .tc(tc2));

    always #5 clk = ~clk;

    // Advance one rising edge, update the model, land 2 time units past the edge.
    task automatic tick();
        @(posedge clk);
        if (!reset) cyc++;
        #2;
    endtask

    task automatic test_reset();
        #7;
        checks++;
        if (q8 !== 8'd0 || tc8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n8: q=%0d tc=%0b, required q=0 tc=0", q8, tc8);
        end
        checks++;
        if (q5 !== 5'd0 || tc5 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n5: q=%0d tc=%0b, required q=0 tc=0", q5, tc5);
        end
        checks++;
        if (q2 !== 2'd0 || tc2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_n2: q=%0d tc=%0b, required q=0 tc=0", q2, tc2);
        end
        #3 reset = 1'b0;
        cyc = 0;
    endtask

    // First 8 edges after release: explicit 1..7,0 sequence for N=8.
    task automatic test_count();
        int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (q8 !== 8'(exp_seq[i]) || tc8 !== (exp_seq[i] == 7)) begin
                errors++;
                $display("FAIL count_edge%0d: q=%0d tc=%0b, required q=%0d tc=%0b",
                         i + 1, q8, tc8, exp_seq[i], exp_seq[i] == 7);
            end
        end
    endtask

    // Alternate moduli, checked against the mod-N model over two of their periods.
    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (q5 !== 5'(cyc % 5) || tc5 !== (cyc % 5 == 4)) begin
                errors++;
                $display("FAIL wrap_n5: q=%0d tc=%0b, required q=%0d tc=%0b",
                         q5, tc5, cyc % 5, cyc % 5 == 4);
            end
            checks++;
            if (q2 !== 2'(cyc % 2) || tc2 !== q2[0]) begin
                errors++;
                $display("FAIL wrap_n2: q=%0d tc=%0b, required q=%0d tc=%0d",
                         q2, tc2, cyc % 2, cyc % 2);
            end
        end
    endtask

    // Async reset while q8 == 5, then 3 full periods counting tc pulses.
    task automatic test_async_reset_long_run();
        int guard = 0;
        int pulses = 0;
        int last_tc = 0;
        while (cyc % 8 != 5 && guard < 20) begin
            tick();
            guard++;
        end
        checks++;
        if (q8 !== 8'd5) begin
            errors++;
            $display("FAIL pre_async_q5: q=%0d, required 5", q8);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (q8 !== 8'd0 || q5 !== 5'd0 || q2 !== 2'd0 || tc8 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: q8=%0d q5=%0d q2=%0d tc8=%0b, required all 0",
                     q8, q5, q2, tc8);
        end
        #2 reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (q8 !== 8'd1) begin
                    errors++;
                    $display("FAIL after_async_first_edge: q=%0d, required 1", q8);
                end
            end
            if (tc8 === 1'b1) begin
                pulses++;
                checks++;
                if (last_tc != 0 || q8 !== 8'd7) begin
                    errors++;
                    $display("FAIL tc_pulse_shape: q=%0d prev_tc=%0d, required q=7 prev_tc=0",
                             q8, last_tc);
                end
            end
            last_tc = (tc8 === 1'b1) ? 1 : 0;
        end
        checks++;
        if (q8 !== 8'd0 || pulses != 3) begin
            errors++;
            $display("FAIL long_run: q=%0d pulses=%0d, required q=0 pulses=3", q8, pulses);
        end
    endtask

    // Random run lengths with random asynchronous resets held across 0..2 edges.
    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            int n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                tick();
                checks++;
                if (q8 !== 8'(cyc % 8) || tc8 !== (cyc % 8 == 7) ||
                    q5 !== 5'(cyc % 5) || tc5 !== (cyc % 5 == 4) ||
                    q2 !== 2'(cyc % 2) || tc2 !== (cyc % 2 == 1)) begin
                    errors++;
                    $display("FAIL random_count: q8=%0d q5=%0d q2=%0d tc=%0b%0b%0b, required q8=%0d q5=%0d q2=%0d",
                             q8, q5, q2, tc8, tc5, tc2, cyc % 8, cyc % 5, cyc % 2);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                int hold = $urandom_range(0, 2);
                #($urandom_range(1, 2)) reset = 1'b1;
                #1;
                checks++;
                if (q8 !== 8'd0 || q5 !== 5'd0 || q2 !== 2'd0) begin
                    errors++;
                    $display("FAIL random_async: q8=%0d q5=%0d q2=%0d, required 0", q8, q5, q2);
                end
                for (int h = 0; h < hold; h++) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (q8 !== 8'd0 || q5 !== 5'd0 || q2 !== 2'd0) begin
                        errors++;
                        $display("FAIL reset_priority: q8=%0d q5=%0d q2=%0d, required 0", q8, q5, q2);
                    end
                end
                @(negedge clk);
                reset = 1'b0;
                cyc = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_async_reset_long_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
